// File: rtl/letter_scroll_ctrl_pkg.sv
// Shared letter-code constants, controller state encoding and the code-sanitising helper.
package letter_scroll_ctrl_pkg;

  localparam logic [3:0] LetA    = 4'd0;
  localparam logic [3:0] LetB    = 4'd1;
  localparam logic [3:0] LetL    = 4'd4;
  localparam logic [3:0] LetDash = 4'd5;
  localparam logic [3:0] LetO    = 4'd7;
  localparam logic [3:0] LetE    = 4'd9;

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  // Codes outside the decoder's alphabet are shown as a dash.
  function automatic logic [3:0] sanitize_code(input logic [3:0] code);
    return (code > LetE) ? LetDash : code;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step prescaler: counts 0..P-1 with P = max(period, 1) and flags the terminal count.
module step_timer #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] period,
  output logic             tc
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] last;

  // >= keeps a shrinking period from overrunning the new terminal value.
  assign last = (period == '0) ? '0 : period - DIV_W'(1);
  assign tc   = en && (cnt_q >= last);

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
    end else if (tc) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/letter_scroll_ctrl.sv
// Scrolls a small buffer of letter codes onto a 7-segment letter decoder,
// one letter per step period, with a dash gap between message passes.
module letter_scroll_ctrl
  import letter_scroll_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [3:0]       wr_code,
  output logic             wr_ready,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] step_div,
  output logic [3:0]       letra,
  output logic             blank,
  output logic             busy,
  output logic             wrap_pulse
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    mem_q [DEPTH];
  logic [3:0]    letra_q, letra_d;
  logic          blank_q, blank_d;
  logic          wrap_q, wrap_d;
  logic          step;
  logic          wr_en;
  logic          idle;

  assign idle     = (state_q == StIdle);
  assign busy     = !idle;
  assign wr_ready = idle && (count_q < CW'(DEPTH));
  assign wr_en    = wr_valid && wr_ready && !clr;

  assign letra      = letra_q;
  assign blank      = blank_q;
  assign wrap_pulse = wrap_q;

  step_timer #(
    .DIV_W (DIV_W)
  ) u_step_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .period (step_div),
    .tc     (step)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[count_q[PW-1:0]] <= sanitize_code(wr_code);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr && idle) begin
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      letra_q  <= LetA;
      blank_q  <= 1'b1;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      letra_q  <= letra_d;
      blank_q  <= blank_d;
      wrap_q   <= wrap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wrap_d   = 1'b0;
    case (state_q)
      StIdle: begin
        // A clear in the same cycle empties the buffer, so it also cancels start.
        if (start && !stop && !clr && (count_q != '0)) begin
          state_d  = StShow;
          rd_ptr_d = '0;
        end
      end
      StShow: begin
        if (stop) begin
          state_d = StIdle;
        end else if (step) begin
          if (CW'(rd_ptr_q) < count_q - CW'(1)) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end else begin
            rd_ptr_d = '0;
            state_d  = StGap;
            wrap_d   = 1'b1;
          end
        end
      end
      StGap: begin
        if (stop) begin
          state_d = StIdle;
        end else if (step) begin
          state_d  = StShow;
          rd_ptr_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    letra_d = LetA;
    blank_d = 1'b1;
    case (state_q)
      StShow: begin
        letra_d = mem_q[rd_ptr_q];
        blank_d = 1'b0;
      end
      StGap: begin
        letra_d = LetDash;
        blank_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
